// File: rtl/xnor_corr_pkg.sv
// Shared types and helpers for the XNOR stream correlator.
package xnor_corr_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } corr_state_e;

    // Bits needed to hold an agreement count of 0..width.
    function automatic int unsigned score_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational agreement count: number of positions where a_i equals b_i.
module xnor_popcount
    import xnor_corr_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SW    = score_w(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [SW-1:0]    agree_c_o
);

    logic [WIDTH-1:0] eq;

    assign eq = ~(a_i ^ b_i);

    always_comb begin
        agree_c_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            agree_c_o = agree_c_o + SW'(eq[i]);
        end
    end

endmodule

// File: rtl/xnor_stream_correlator.sv
// Bit-serial correlator: shifts bits into a window and scores it against a pattern.
// Optional saturating match counter enabled by defining CORR_MATCH_CNT_EN.
module xnor_stream_correlator
    import xnor_corr_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned SW    = score_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] pat,
    input  logic [SW-1:0]    thresh,
    output logic             out_valid,
    output logic [SW-1:0]    score,
    output logic             match,
    output logic             filled
`ifdef CORR_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned FCW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || CNT_W < 1) begin : g_param_check
        $error("xnor_stream_correlator: WIDTH must be 2..64 and CNT_W >= 1");
    end

    corr_state_e      state_q, state_d;
    logic [FCW-1:0]   fill_q, fill_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic             filled_q, filled_d;
    logic             pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    score_q, score_d;
    logic             match_q, match_d;
    logic [SW-1:0]    agree;

    xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
        .a_i       (win_q),
        .b_i       (pat),
        .agree_c_o (agree)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            fill_q      <= '0;
            win_q       <= '0;
            filled_q    <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            score_q     <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            win_q       <= win_d;
            filled_q    <= filled_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            score_q     <= score_d;
            match_q     <= match_d;
        end
    end

    // pend_q marks a window that became full on the previous edge; it is scored one edge later.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        win_d       = win_q;
        filled_d    = filled_q;
        pend_d      = 1'b0;
        out_valid_d = 1'b0;
        score_d     = score_q;
        match_d     = match_q;

        if (clear) begin
            state_d  = ST_FILL;
            fill_d   = '0;
            win_d    = '0;
            filled_d = 1'b0;
        end else begin
            if (pend_q) begin
                out_valid_d = 1'b1;
                score_d     = agree;
                match_d     = (agree >= thresh);
            end
            if (in_valid) begin
                win_d = {win_q[WIDTH-2:0], in_bit};
                unique case (state_q)
                    ST_FILL: begin
                        if (fill_q == FCW'(WIDTH - 1)) begin
                            state_d  = ST_RUN;
                            fill_d   = '0;
                            filled_d = 1'b1;
                            pend_d   = 1'b1;
                        end else begin
                            fill_d = fill_q + FCW'(1);
                        end
                    end
                    ST_RUN: pend_d = 1'b1;
                    default: state_d = ST_FILL;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign score     = score_q;
    assign match     = match_q;
    assign filled    = filled_q;

`ifdef CORR_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counts edges that register a qualified match; sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (out_valid_d && match_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_xnor_stream_correlator.sv
// Directed, table-driven bench for xnor_stream_correlator (WIDTH=8).
module tb_xnor_stream_correlator;

    localparam logic [7:0] P = 8'b10110010;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_bit;
    logic [7:0] pat;
    logic [3:0] thresh;
    logic       out_valid;
    logic [3:0] score;
    logic       match;
    logic       filled;
`ifdef CORR_MATCH_CNT_EN
    logic [1:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    xnor_stream_correlator #(.WIDTH(8), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .pat       (pat),
        .thresh    (thresh),
        .out_valid (out_valid),
        .score     (score),
        .match     (match),
        .filled    (filled)
`ifdef CORR_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       iv;
        logic       b;
        logic [7:0] p;
        logic [3:0] thr;
        logic       ov;
        logic [3:0] sc;
        logic       m;
        logic       f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic iv, input logic b, input logic [7:0] p,
                        input logic [3:0] thr);
        clear    = c;
        in_valid = iv;
        in_bit   = b;
        pat      = p;
        thresh   = thr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [3:0] sc,
                              input logic m, input logic f);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".score"},     32'(score),     32'(sc));
        check({tag, ".match"},     32'(match),     32'(m));
        check({tag, ".filled"},    32'(filled),    32'(f));
    endtask

    task automatic add(input logic c, input logic iv, input logic b, input logic [7:0] p,
                       input logic [3:0] thr, input logic ov, input logic [3:0] sc,
                       input logic m, input logic f);
        vecs.push_back('{clr: c, iv: iv, b: b, p: p, thr: thr, ov: ov, sc: sc, m: m, f: f});
    endtask

    initial begin
        logic [7:0] seq;

        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        pat      = P;
        thresh   = 4'd8;

        // Fill from 1,0,1,1,0,0,1,0 then run, gaps, thresh edges, pat changes, clear
        seq = 8'b10110010;
        for (int i = 0; i < 8; i++) add(0, 1, seq[7-i], P, 8, 0, 0, 0, (i == 7));
        add(0, 1, 1, P,     8,  1, 8, 1, 1);
        add(0, 0, 0, P,     8,  1, 2, 0, 1);
        add(0, 1, 1, P,     8,  0, 2, 0, 1);
        add(0, 0, 0, P,     3,  1, 3, 1, 1);
        add(0, 0, 0, P,     3,  0, 3, 1, 1);
        add(0, 1, 0, P,     3,  0, 3, 1, 1);
        add(0, 0, 0, P,     4,  1, 6, 1, 1);
        add(0, 0, 0, P,     4,  0, 6, 1, 1);
        add(0, 1, 1, P,     4,  0, 6, 1, 1);
        add(0, 0, 0, P,     9,  1, 2, 0, 1);
        add(0, 1, 0, P,     9,  0, 2, 0, 1);
        add(0, 0, 0, P,     0,  1, 4, 1, 1);
        add(0, 1, 1, P,     0,  0, 4, 1, 1);
        add(0, 1, 0, P,     15, 1, 5, 0, 1);
        add(0, 1, 1, 8'h00, 2,  1, 4, 1, 1);
        add(0, 1, 0, 8'hFF, 5,  1, 5, 1, 1);
        add(1, 1, 1, P,     8,  0, 5, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 1, seq[7-i], P, 8, 0, 5, 1, (i == 7));
        add(0, 0, 0, P,     8,  1, 8, 1, 1);

        // Reset held with in_valid toggling
        for (int i = 0; i < 4; i++) begin
            step(0, logic'(i % 2 == 0), 1, P, 0);
            check_outs("reset", 0, 0, 0, 0);
        end
`ifdef CORR_MATCH_CNT_EN
        check("reset.match_cnt", 32'(match_cnt), 0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].iv, vecs[i].b, vecs[i].p, vecs[i].thr);
            check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].sc, vecs[i].m, vecs[i].f);
        end

        // Flush, then thresh=0 stream: every output matches, counter saturates at 3
        step(1, 0, 0, P, 0);
        check_outs("flush", 0, 8, 1, 0);
`ifdef CORR_MATCH_CNT_EN
        check("flush.match_cnt", 32'(match_cnt), 0);
`endif
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, P, 0);
            check(.name($sformatf("cnt_run%0d.out_valid", i)), .act(32'(out_valid)),
                  .exp(32'(i >= 8)));
`ifdef CORR_MATCH_CNT_EN
            check($sformatf("cnt_run%0d.match_cnt", i), 32'(match_cnt),
                  (i < 8) ? 0 : ((i - 7 > 3) ? 3 : i - 7));
`endif
        end
        step(0, 0, 0, P, 0);
        check_outs("cnt_tail", 1, 4, 1, 1);
`ifdef CORR_MATCH_CNT_EN
        check("cnt_tail.match_cnt", 32'(match_cnt), 3);
`endif

        // Mid-stream async reset with a result in flight
        step(0, 1, 0, P, 0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0, 0);
`ifdef CORR_MATCH_CNT_EN
        check("midrst.match_cnt", 32'(match_cnt), 0);
`endif
        @(posedge clk);
        #1;
        check("midrst_hold.out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, seq[7-i], P, 8);
            check_outs($sformatf("refill%0d", i), 0, 0, 0, (i == 7));
        end
        step(0, 0, 0, P, 8);
        check_outs("refill_out", 1, 8, 1, 1);
        step(0, 0, 0, P, 8);
        check_outs("refill_idle", 0, 8, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
